// File: rtl/seq_alu.sv
// seq_alu: registered ALU with a Start/Done handshake. It runs one operation per
// transaction and holds Result and Flags {CARRY, EQUAL, PARITY, BEVEN, ZERO}
// until the next completion.
// LSL/LSR shift one bit per cycle in the SHIFT state. When the macro
// SEQ_ALU_FAST_SHIFT_EN is defined, a barrel shifter is used instead and every
// operation completes in a single cycle.
module seq_alu #(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic [2:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Carry_in,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Result,
    output logic [4:0]       Flags
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_LSL = 3'd1;
    localparam logic [2:0] OP_XOR = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_CMP = 3'd4;
    localparam logic [2:0] OP_SET = 3'd5;
    localparam logic [2:0] OP_LSR = 3'd6;
    localparam logic [2:0] OP_SUB = 3'd7;

    localparam logic [CNT_W-1:0] AMT_MAX = CNT_W'(WIDTH);

    typedef enum logic {S_IDLE, S_SHIFT} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] amt, cnt;
    logic [WIDTH-1:0] work, work_nxt, imm_res;
    logic [WIDTH:0]   sum, diff;
    logic [4:0]       imm_flags;
    logic             shift_left, parity_r, equal_r;
    logic             go_shift, imm_done, last_step, out_bit;
    logic             imm_carry, imm_write;

    // Flags are always built from a carry, the captured-operand bits and a result word.
    function automatic logic [4:0] pack_flags(input logic carry, input logic equal,
                                              input logic parity, input logic [WIDTH-1:0] r);
        return {carry, equal, parity, ~r[0], (r == '0)};
    endfunction

    // Amounts of WIDTH or more all clamp to WIDTH, which clears the word.
    assign amt  = (B >= WIDTH'(WIDTH)) ? AMT_MAX : B[CNT_W-1:0];
    assign sum  = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, Carry_in};
    assign diff = {1'b0, A} - {1'b0, B} - {{WIDTH{1'b0}}, Carry_in};

`ifdef SEQ_ALU_FAST_SHIFT_EN
    assign go_shift = 1'b0;
`else
    assign go_shift = ((Op == OP_LSL) || (Op == OP_LSR)) && (amt != '0);
`endif

    // Single-cycle evaluation of every operation that finishes on the Start edge.
    always_comb begin
        imm_res   = '0;
        imm_carry = 1'b0;
        imm_write = 1'b1;
        case (Op)
            OP_ADD: {imm_carry, imm_res} = sum;
            OP_SUB: {imm_carry, imm_res} = diff;
            OP_XOR: imm_res = A ^ B;
            OP_AND: imm_res = A & B;
            OP_SET: imm_res = B;
            OP_CMP: begin
                imm_res   = diff[WIDTH-1:0] + {{(WIDTH-1){1'b0}}, Carry_in};
                imm_carry = (A < B);
                imm_write = 1'b0;
            end
`ifdef SEQ_ALU_FAST_SHIFT_EN
            OP_LSL: {imm_carry, imm_res} = {1'b0, A} << amt;
            OP_LSR: {imm_res, imm_carry} = {A, 1'b0} >> amt;
`else
            // Only zero-amount shifts take this path: the word passes through unchanged.
            OP_LSL: imm_res = A;
            OP_LSR: imm_res = A;
`endif
            default: imm_res = '0;
        endcase
        imm_flags = pack_flags(imm_carry, (A == B), ^A, imm_res);
    end

    // One-bit step of the iterative shifter; out_bit is the bit leaving the word.
    always_comb begin
        if (shift_left) begin
            work_nxt = {work[WIDTH-2:0], 1'b0};
            out_bit  = work[WIDTH-1];
        end else begin
            work_nxt = {1'b0, work[WIDTH-1:1]};
            out_bit  = work[0];
        end
    end

    // State register.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // Next-state logic: Start is only looked at in IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (Start && go_shift) state_nxt = S_SHIFT;
            S_SHIFT: if (cnt == CNT_W'(1))  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs: busy indication and the two kinds of completion.
    always_comb begin
        Busy      = (state == S_SHIFT);
        imm_done  = (state == S_IDLE) && Start && !go_shift;
        last_step = (state == S_SHIFT) && (cnt == CNT_W'(1));
    end

    // Datapath: operand capture, shift iteration and result/flag writeback.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            Done       <= 1'b0;
            Result     <= '0;
            Flags      <= '0;
            work       <= '0;
            cnt        <= '0;
            shift_left <= 1'b0;
            parity_r   <= 1'b0;
            equal_r    <= 1'b0;
        end else begin
            Done <= imm_done || last_step;
            if ((state == S_IDLE) && Start && go_shift) begin
                work       <= A;
                cnt        <= amt;
                shift_left <= (Op == OP_LSL);
                parity_r   <= ^A;
                equal_r    <= (A == B);
            end
            if (imm_done) begin
                if (imm_write) Result <= imm_res;
                Flags <= imm_flags;
            end
            if (state == S_SHIFT) begin
                work <= work_nxt;
                cnt  <= cnt - CNT_W'(1);
            end
            if (last_step) begin
                Result <= work_nxt;
                Flags  <= pack_flags(out_bit, equal_r, parity_r, work_nxt);
            end
        end
    end
endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu (WIDTH=8): a vector table plus hand-written
// sequences for reset, busy-time Start, and Start during the Done cycle.
module tb_seq_alu;
    localparam int WIDTH = 8;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_LSL = 3'd1;
    localparam logic [2:0] OP_XOR = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_CMP = 3'd4;
    localparam logic [2:0] OP_SET = 3'd5;
    localparam logic [2:0] OP_LSR = 3'd6;
    localparam logic [2:0] OP_SUB = 3'd7;

    logic             Clk = 1'b0;
    logic             Reset_n;
    logic             Start;
    logic [2:0]       Op;
    logic [WIDTH-1:0] A, B;
    logic             Carry_in;
    logic             Busy, Done;
    logic [WIDTH-1:0] Result;
    logic [4:0]       Flags;

    int total = 0;
    int bad   = 0;

    seq_alu #(.WIDTH(WIDTH)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Op(Op), .A(A), .B(B),
        .Carry_in(Carry_in), .Busy(Busy), .Done(Done), .Result(Result), .Flags(Flags)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] res;
        logic [4:0] fl;     // {CARRY, EQUAL, PARITY, BEVEN, ZERO}
        int         edges;  // clock edges after the Start edge until Done is seen
    } vec_t;

    vec_t vecs[18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge where Done is seen.
    task automatic run_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic cin, output logic [7:0] res, output logic [4:0] fl,
                          output int edges, output int busy_cnt);
        Start = 1'b1; Op = op; A = a; B = b; Carry_in = cin;
        @(posedge Clk);
        @(negedge Clk);
        Start = 1'b0;
        edges = 0;
        busy_cnt = 0;
        while (!Done && edges < 40) begin
            if (Busy) busy_cnt++;
            @(posedge Clk);
            @(negedge Clk);
            edges++;
        end
        check("done_seen", {31'b0, Done}, 32'd1);
        res = Result;
        fl  = Flags;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] r;
        logic [4:0] f;
        int e, bc, exp_e, dones;

        vecs[0]  = '{OP_ADD, 8'hFF, 8'h01, 1'b0, 8'h00, 5'b10011, 0};
        vecs[1]  = '{OP_SUB, 8'h03, 8'h05, 1'b0, 8'hFE, 5'b10010, 0};
        vecs[2]  = '{OP_ADD, 8'h0F, 8'h01, 1'b0, 8'h10, 5'b00010, 0};
        vecs[3]  = '{OP_CMP, 8'h07, 8'h07, 1'b0, 8'h10, 5'b01111, 0};
        vecs[4]  = '{OP_CMP, 8'h02, 8'h09, 1'b0, 8'h10, 5'b10100, 0};
        vecs[5]  = '{OP_LSL, 8'h81, 8'h03, 1'b0, 8'h08, 5'b00010, 3};
        vecs[6]  = '{OP_LSR, 8'h81, 8'h09, 1'b0, 8'h00, 5'b10011, 8};
        vecs[7]  = '{OP_LSR, 8'h55, 8'h00, 1'b0, 8'h55, 5'b00000, 0};
        vecs[8]  = '{OP_XOR, 8'hA5, 8'h5A, 1'b0, 8'hFF, 5'b00000, 0};
        vecs[9]  = '{OP_AND, 8'hF0, 8'h3C, 1'b0, 8'h30, 5'b00010, 0};
        vecs[10] = '{OP_SET, 8'h12, 8'h12, 1'b0, 8'h12, 5'b01010, 0};
        vecs[11] = '{OP_SUB, 8'h10, 8'h0F, 1'b1, 8'h00, 5'b00111, 0};
        vecs[12] = '{OP_ADD, 8'h7F, 8'h80, 1'b1, 8'h00, 5'b10111, 0};
        vecs[13] = '{OP_LSL, 8'h03, 8'h08, 1'b0, 8'h00, 5'b10011, 8};
        vecs[14] = '{OP_LSR, 8'h06, 8'h01, 1'b0, 8'h03, 5'b00000, 1};
        vecs[15] = '{OP_LSL, 8'hC0, 8'h02, 1'b0, 8'h00, 5'b10011, 2};
        vecs[16] = '{OP_SUB, 8'h00, 8'h00, 1'b1, 8'hFF, 5'b11000, 0};
        vecs[17] = '{OP_ADD, 8'h00, 8'h00, 1'b0, 8'h00, 5'b01011, 0};

        // Reset held with random inputs toggling.
        Reset_n = 1'b0;
        Start = 1'b0; Op = '0; A = '0; B = '0; Carry_in = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge Clk);
            Start = 1'($urandom); Op = 3'($urandom); A = 8'($urandom);
            B = 8'($urandom); Carry_in = 1'($urandom);
            check("rst_busy",   {31'b0, Busy},   32'd0);
            check("rst_done",   {31'b0, Done},   32'd0);
            check("rst_result", {24'b0, Result}, 32'd0);
            check("rst_flags",  {27'b0, Flags},  32'd0);
        end
        @(negedge Clk);
        Start = 1'b0;
        Reset_n = 1'b1;
        @(negedge Clk);

        // Vector table.
        for (int i = 0; i < 18; i++) begin
`ifdef SEQ_ALU_FAST_SHIFT_EN
            exp_e = 0;
`else
            exp_e = vecs[i].edges;
`endif
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin, r, f, e, bc);
            check($sformatf("v%0d_result", i), {24'b0, r}, {24'b0, vecs[i].res});
            check($sformatf("v%0d_flags", i),  {27'b0, f}, {27'b0, vecs[i].fl});
            check($sformatf("v%0d_latency", i), e, exp_e);
            check($sformatf("v%0d_busy", i), bc, exp_e);
        end

        // Start in the Done cycle is accepted; back-to-back non-shift ops.
        Start = 1'b1; Op = OP_ADD; A = 8'h01; B = 8'h01; Carry_in = 1'b0;
        @(posedge Clk);
        @(negedge Clk);
        check("b2b_done1",   {31'b0, Done},   32'd1);
        check("b2b_result1", {24'b0, Result}, 32'h02);
        Op = OP_SUB; A = 8'h05; B = 8'h01;
        @(posedge Clk);
        @(negedge Clk);
        check("b2b_done2",   {31'b0, Done},   32'd1);
        check("b2b_result2", {24'b0, Result}, 32'h04);
        check("b2b_flags2",  {27'b0, Flags},  32'b00010);
        Start = 1'b0;
        @(posedge Clk);
        @(negedge Clk);
        check("b2b_done_pulse", {31'b0, Done},   32'd0);
        check("b2b_hold",       {24'b0, Result}, 32'h04);

`ifndef SEQ_ALU_FAST_SHIFT_EN
        // Start pulsed while busy is dropped, not queued.
        run_op(OP_SET, 8'h00, 8'h12, 1'b0, r, f, e, bc);
        Start = 1'b1; Op = OP_LSL; A = 8'h01; B = 8'h04;
        @(posedge Clk);
        @(negedge Clk);
        Start = 1'b0;
        @(posedge Clk);
        @(negedge Clk);
        check("ign_busy",        {31'b0, Busy},   32'd1);
        check("ign_result_held", {24'b0, Result}, 32'h12);
        Start = 1'b1; Op = OP_SET; A = 8'h00; B = 8'hAA;
        @(posedge Clk);
        @(negedge Clk);
        Start = 1'b0;
        e = 0;
        while (!Done && e < 20) begin
            @(posedge Clk);
            @(negedge Clk);
            e++;
        end
        check("ign_done_seen", {31'b0, Done},   32'd1);
        check("ign_result",    {24'b0, Result}, 32'h10);
        check("ign_flags",     {27'b0, Flags},  32'b00110);
        dones = 0;
        for (int k = 0; k < 3; k++) begin
            @(posedge Clk);
            @(negedge Clk);
            if (Done) dones++;
        end
        check("ign_no_extra_done", dones, 0);
        check("ign_result_final",  {24'b0, Result}, 32'h10);
`endif

        // Reset asserted in the middle of an LSL by 5.
        run_op(OP_SET, 8'h00, 8'h33, 1'b0, r, f, e, bc);
        check("pre_abort_result", {24'b0, r}, 32'h33);
        Start = 1'b1; Op = OP_LSL; A = 8'h0F; B = 8'h05;
        @(posedge Clk);
        @(negedge Clk);
        Start = 1'b0;
`ifndef SEQ_ALU_FAST_SHIFT_EN
        check("abort_busy_before", {31'b0, Busy}, 32'd1);
`endif
        @(posedge Clk);
        @(negedge Clk);
        Reset_n = 1'b0;
        #1;
        check("abort_busy",   {31'b0, Busy},   32'd0);
        check("abort_done",   {31'b0, Done},   32'd0);
        check("abort_result", {24'b0, Result}, 32'd0);
        check("abort_flags",  {27'b0, Flags},  32'd0);
        @(negedge Clk);
        Reset_n = 1'b1;
        dones = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge Clk);
            @(negedge Clk);
            if (Done) dones++;
        end
        check("abort_no_done",      dones, 0);
        check("abort_result_after", {24'b0, Result}, 32'd0);
        check("abort_flags_after",  {27'b0, Flags},  32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
